// File: rtl/dac_spi_if.sv
// ============================================================================
// dac_spi_if : sample-load handshake plus DAC serial pins for dac_spi_tx
// Revision   : 1.0
// ============================================================================
`default_nettype none

interface dac_spi_if;
  logic       load;
  logic [9:0] data_in;
  logic       dac_cs_n;
  logic       dac_sck;
  logic       dac_sdi;
  logic       dac_ld_n;
  logic       busy;
  logic       done;
  logic       overrun;

  modport master (
    output load, data_in,
    input  dac_cs_n, dac_sck, dac_sdi, dac_ld_n, busy, done, overrun
  );

  modport slave (
    input  load, data_in,
    output dac_cs_n, dac_sck, dac_sdi, dac_ld_n, busy, done, overrun
  );
endinterface

`default_nettype wire

// File: rtl/dac_spi_tx.sv
// ============================================================================
// dac_spi_tx : 16-bit write-frame SPI transmitter for a 10-bit serial DAC,
//              with a one-deep pending sample buffer
// Revision   : 1.0
// ============================================================================
`default_nettype none

module dac_spi_tx #(
  parameter int HALF   = 25,
  parameter bit BUF    = 1'b0,
  parameter bit GA_N   = 1'b1,
  parameter bit SHDN_N = 1'b1
) (
  input  wire logic   sysclk,
  input  wire logic   rst_n,
  dac_spi_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_LATCH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] c_RELOAD = 8'(HALF - 1);
  localparam logic [3:0] c_HDR    = {1'b0, BUF, GA_N, SHDN_N};

  function automatic logic [15:0] frame_of(input logic [9:0] d);
    return {c_HDR, d, 2'b00};
  endfunction

  state_t      r_state, w_state;
  logic [7:0]  r_cnt, w_cnt;
  logic [4:0]  r_slot, w_slot;
  logic        r_phase, w_phase;     // 1 = SCK-high half of the slot
  logic [15:0] r_shift, w_shift;
  logic        r_pend, w_pend;
  logic [9:0]  r_pend_data, w_pend_data;

  logic r_cs_n, r_sck, r_sdi, r_ld_n, r_busy, r_done, r_overrun;
  logic w_cs_n, w_sck, w_sdi, w_ld_n, w_busy, w_done, w_overrun;
  logic w_last;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_slot      <= 5'd0;
      r_phase     <= 1'b0;
      r_shift     <= 16'd0;
      r_pend      <= 1'b0;
      r_pend_data <= 10'd0;
      r_cs_n      <= 1'b1;
      r_sck       <= 1'b0;
      r_sdi       <= 1'b0;
      r_ld_n      <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_slot      <= w_slot;
      r_phase     <= w_phase;
      r_shift     <= w_shift;
      r_pend      <= w_pend;
      r_pend_data <= w_pend_data;
      r_cs_n      <= w_cs_n;
      r_sck       <= w_sck;
      r_sdi       <= w_sdi;
      r_ld_n      <= w_ld_n;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_overrun   <= w_overrun;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_slot      = r_slot;
    w_phase     = r_phase;
    w_shift     = r_shift;
    w_pend      = r_pend;
    w_pend_data = r_pend_data;
    w_overrun   = 1'b0;
    w_last      = (r_cnt == 8'd0);

    case (r_state)
      S_IDLE: begin
        if (bus.load) begin
          w_state = S_SETUP;
          w_cnt   = c_RELOAD;
          w_shift = frame_of(bus.data_in);
        end
      end
      S_SETUP: begin
        if (w_last) begin
          w_state = S_SHIFT;
          w_phase = 1'b1;
          w_slot  = 5'd0;
          w_cnt   = c_RELOAD;
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end
      S_SHIFT: begin
        if (!w_last) begin
          w_cnt = r_cnt - 8'd1;
        end else if (r_phase) begin
          // SDI moves on the falling SCK edge, giving H cycles of hold and setup
          w_phase = 1'b0;
          w_cnt   = c_RELOAD;
          w_shift = {r_shift[14:0], 1'b0};
        end else if (r_slot == 5'd15) begin
          w_state = S_LATCH;
          w_cnt   = c_RELOAD;
        end else begin
          w_slot  = r_slot + 5'd1;
          w_phase = 1'b1;
          w_cnt   = c_RELOAD;
        end
      end
      S_LATCH: begin
        if (w_last) begin
          w_state = S_DONE;
          w_cnt   = c_RELOAD;
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end
      S_DONE: begin
        w_cnt = c_RELOAD;
        if (bus.load) begin
          w_shift   = frame_of(bus.data_in);
          w_pend    = 1'b0;
          w_overrun = r_pend;
          w_state   = S_SETUP;
        end else if (r_pend) begin
          w_shift = frame_of(r_pend_data);
          w_pend  = 1'b0;
          w_state = S_SETUP;
        end else begin
          w_state = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    if (bus.load && (r_state inside {S_SETUP, S_SHIFT, S_LATCH})) begin
      w_pend      = 1'b1;
      w_pend_data = bus.data_in;
      w_overrun   = r_pend;
    end

    // Outputs are registered from the next state so they line up with it
    w_cs_n = !(w_state == S_SETUP || w_state == S_SHIFT);
    w_sck  = (w_state == S_SHIFT) && w_phase;
    w_sdi  = !w_cs_n && w_shift[15];
    w_ld_n = (w_state != S_LATCH);
    w_busy = (w_state != S_IDLE);
    w_done = (w_state == S_DONE);
  end

  assign bus.dac_cs_n = r_cs_n;
  assign bus.dac_sck  = r_sck;
  assign bus.dac_sdi  = r_sdi;
  assign bus.dac_ld_n = r_ld_n;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.overrun  = r_overrun;

endmodule

`default_nettype wire
